// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: segment-count
// type, segment-count helper and the parameter legality check.
package addsub_pkg;

    // Number of carry-pipeline segments (equals the latency in cycles).
    typedef int unsigned seg_count_t;

    // Number of segments for a given operand width and segment width.
    function automatic seg_count_t calc_nseg(input int unsigned width, input int unsigned seg_w);
        return seg_count_t'(width / seg_w);
    endfunction

    // Legal geometry: at least two bits per segment, whole segments only.
    function automatic bit params_ok(input int unsigned width, input int unsigned seg_w);
        return (seg_w >= 2) && (width >= seg_w) && ((width % seg_w) == 0);
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result bus of the pipelined add/subtract unit. The master side
// supplies operands and accepts results; the slave side is the unit.
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
) ();
    // Operand side.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;

    // Result side.
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/addsub_segment.sv
// Combinational SEG_W-bit ripple chain of full-adder cells. Besides the
// segment sum and carry out it exposes the carry into its top bit, which the
// most significant segment needs for signed overflow detection.
module addsub_segment #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             c_i,
    output logic [SEG_W-1:0] s_o,
    output logic             c_o,
    output logic             c_top_o
);
    // Each bit keeps its own carry nets so the chain is a plain sequence of
    // scalars rather than a vector that feeds back into itself.
    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        logic c_in;
        logic c_out;

        if (i == 0) begin : g_lsb
            assign c_in = c_i;
        end else begin : g_chain
            assign c_in = g_bit[i-1].c_out;
        end

        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (c_in),
            .s_o (s_o[i]),
            .c_o (c_out)
        );
    end

    assign c_o     = g_bit[SEG_W-1].c_out;
    assign c_top_o = g_bit[SEG_W-1].c_in;
endmodule

// File: rtl/full_adder.sv
// One-bit full-adder cell; the building block of every segment ripple chain.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/pipelined_addsub.sv
// Carry-pipelined add/subtract unit. Operands are cut into SEG_W-bit
// segments; stage k adds segment k and registers its carry for stage k+1.
// Not-yet-used operand segments ride along in skew registers, finished sum
// segments in deskew registers, so one result completes per cycle.
// A single global stall freezes every register while a result waits.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_addsub_if.slave bus
);
    localparam seg_count_t NSEG = calc_nseg(WIDTH, SEG_W);

    if (!params_ok(WIDTH, SEG_W)) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be a multiple of SEG_W and SEG_W must be >= 2");
    end

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Condition operand B and the initial carry for add or subtract.
    // NOTE: every signal written in an always_comb is assigned on every path,
    // otherwise synthesis infers a latch to remember the old value.
    always_comb begin
        b_eff = bus.b;
        c0    = bus.cin;
        if (bus.sub) begin
            b_eff = ~bus.b;
            c0    = 1'b1;
        end
    end

    // A result that cannot leave freezes the whole pipe; accepting input
    // never depends on in_valid.
    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO     = k * SEG_W;
        localparam int HI     = LO + SEG_W - 1;
        localparam int DONE_W = LO + SEG_W;

        // Operand bits still to be processed from this stage upward.
        logic [WIDTH-1:LO]  src_a;
        logic [WIDTH-1:LO]  src_b;
        logic               src_c;
        logic [SEG_W-1:0]   seg_s;
        logic               seg_c;
        logic               seg_c_top;
        logic               valid_d;
        logic               valid_q;
        logic               carry_d;
        logic               carry_q;
        logic [DONE_W-1:0]  sum_d;
        logic [DONE_W-1:0]  sum_q;

        if (k == 0) begin : g_head
            assign src_a   = bus.a;
            assign src_b   = b_eff;
            assign src_c   = c0;
            assign valid_d = bus.in_valid;
            assign sum_d   = seg_s;
        end else begin : g_body
            assign src_a   = g_stage[k-1].g_skew.opa_q;
            assign src_b   = g_stage[k-1].g_skew.opb_q;
            assign src_c   = g_stage[k-1].carry_q;
            assign valid_d = g_stage[k-1].valid_q;
            assign sum_d   = {seg_s, g_stage[k-1].sum_q};
        end

        addsub_segment #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a_i     (src_a[HI:LO]),
            .b_i     (src_b[HI:LO]),
            .c_i     (src_c),
            .s_o     (seg_s),
            .c_o     (seg_c),
            .c_top_o (seg_c_top)
        );

        assign carry_d = seg_c;

        // Stage register: valid bit, segment carry and the sum bits so far.
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of its neighbours.
        // NOTE: the data registers are reset as well as the valid bits, so the
        // result fields are 0 rather than unknown after reset and while idle.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (!stall) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        if (k < NSEG - 1) begin : g_skew
            logic [WIDTH-1:DONE_W] opa_d;
            logic [WIDTH-1:DONE_W] opa_q;
            logic [WIDTH-1:DONE_W] opb_d;
            logic [WIDTH-1:DONE_W] opb_q;
            // The carry into the top bit only matters in the MSB segment.
            logic                  unused_c_top;

            assign opa_d        = src_a[WIDTH-1:DONE_W];
            assign opb_d        = src_b[WIDTH-1:DONE_W];
            assign unused_c_top = seg_c_top;

            // Skew registers carrying the operand segments of later stages.
            always_ff @(posedge clk) begin
                if (rst) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (!stall) begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                end
            end
        end else begin : g_last
            logic ctop_d;
            logic ctop_q;

            assign ctop_d = seg_c_top;

            // Carry into the MSB, kept next to the final carry for overflow.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ctop_q <= 1'b0;
                end else if (!stall) begin
                    ctop_q <= ctop_d;
                end
            end
        end
    end

    assign bus.out_valid = g_stage[NSEG-1].valid_q;
    assign bus.sum       = g_stage[NSEG-1].sum_q;
    assign bus.cout      = g_stage[NSEG-1].carry_q;
    assign bus.ovf       = g_stage[NSEG-1].carry_q ^ g_stage[NSEG-1].g_last.ctop_q;
endmodule
